// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction memory between the core fetch port
// (read) and the program loader (write).
//   BOOT : only the loader is served; fetch is held off until load_done.
//   RUN  : fetch has priority; a loader request denied MAX_WAIT consecutive
//          cycles is forced through on the next cycle (fetch waits).
// Read data from the combinational memory port is registered (latency 1).
// Optional build macro: IMEM_MISALIGN_CHECK_EN
//   defined     -> accesses with addr[1:0] != 0 complete their handshake but
//                  never reach memory; fetch returns rvalid=1, err=1, rdata=0,
//                  loader writes are dropped.
//   not defined -> addresses pass through unchanged; fetch_err is always 0.
module imem_arbiter #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_done,
   input  logic             fetch_req,
   input  logic [WIDTH-1:0] fetch_addr,
   output logic             fetch_gnt,
   output logic             fetch_rvalid,
   output logic [WIDTH-1:0] fetch_rdata,
   output logic             fetch_err,
   input  logic             load_req,
   input  logic [WIDTH-1:0] load_addr,
   input  logic [WIDTH-1:0] load_wdata,
   output logic             load_gnt,
   output logic [WIDTH-1:0] mem_addr,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             state_run
);

   localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic               fetch_rvalid_q, fetch_rvalid_d;
   logic [WIDTH-1:0]   fetch_rdata_q, fetch_rdata_d;
   logic               fetch_err_q, fetch_err_d;
   logic               force_load;
   logic               fetch_misal;
   logic               load_misal;

   // Address alignment qualification for the optional misalignment check
   always_comb begin
`ifdef IMEM_MISALIGN_CHECK_EN
      fetch_misal = (fetch_addr[1:0] != 2'b00);
      load_misal  = (load_addr[1:0] != 2'b00);
`else
      fetch_misal = 1'b0;
      load_misal  = 1'b0;
`endif
   end

   // Grant arbitration: BOOT serves only the loader, RUN favours fetch with a starvation bound
   always_comb begin
      fetch_gnt  = 1'b0;
      load_gnt   = 1'b0;
      force_load = 1'b0;
      unique case (state_q)
         ST_BOOT: begin
            load_gnt = load_req;
         end
         ST_RUN: begin
            force_load = (wait_cnt_q == WAIT_MAX);
            load_gnt   = load_req & (~fetch_req | force_load);
            // A forced loader grant steals the cycle; fetch stays pending
            fetch_gnt  = fetch_req & ~load_gnt;
         end
         default: begin
            fetch_gnt = 1'b0;
            load_gnt  = 1'b0;
         end
      endcase
   end

   // Memory port mux: the granted requester drives the memory, idle drives zeros
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (load_gnt) begin
         if (!load_misal) begin
            mem_addr  = load_addr;
            mem_wdata = load_wdata;
            mem_we    = 1'b1;
         end
      end else if (fetch_gnt) begin
         if (!fetch_misal) begin
            mem_addr = fetch_addr;
         end
      end
   end

   // Next-state, starvation counter and read-return computation
   always_comb begin
      state_d        = state_q;
      wait_cnt_d     = '0;
      fetch_rvalid_d = fetch_gnt;
      fetch_rdata_d  = fetch_rdata_q;
      fetch_err_d    = fetch_err_q;

      unique case (state_q)
         ST_BOOT: begin
            if (load_done) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (load_req && !load_gnt) begin
               wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase

      if (fetch_gnt) begin
         fetch_rdata_d = fetch_misal ? '0 : mem_rdata;
         fetch_err_d   = fetch_misal;
      end
   end

   // State and read-return registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_BOOT;
         wait_cnt_q     <= '0;
         fetch_rvalid_q <= 1'b0;
         fetch_rdata_q  <= '0;
         fetch_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         fetch_rvalid_q <= fetch_rvalid_d;
         fetch_rdata_q  <= fetch_rdata_d;
         fetch_err_q    <= fetch_err_d;
      end
   end

   assign fetch_rvalid = fetch_rvalid_q;
   assign fetch_rdata  = fetch_rdata_q;
   assign fetch_err    = fetch_err_q;
   assign state_run    = (state_q == ST_RUN);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed testbench for imem_arbiter with a small word-organised memory model.
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 1 unit later, registered outputs 1 unit after the following edge.
module tb_imem_arbiter;

   localparam int unsigned WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             load_done;
   logic             fetch_req;
   logic [WIDTH-1:0] fetch_addr;
   logic             fetch_gnt;
   logic             fetch_rvalid;
   logic [WIDTH-1:0] fetch_rdata;
   logic             fetch_err;
   logic             load_req;
   logic [WIDTH-1:0] load_addr;
   logic [WIDTH-1:0] load_wdata;
   logic             load_gnt;
   logic [WIDTH-1:0] mem_addr;
   logic             mem_we;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             state_run;

   int tests_run;
   int tests_failed;

   logic [WIDTH-1:0] mem [16];

   imem_arbiter #(
      .WIDTH    (WIDTH),
      .MAX_WAIT (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_done    (load_done),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_gnt    (fetch_gnt),
      .fetch_rvalid (fetch_rvalid),
      .fetch_rdata  (fetch_rdata),
      .fetch_err    (fetch_err),
      .load_req     (load_req),
      .load_addr    (load_addr),
      .load_wdata   (load_wdata),
      .load_gnt     (load_gnt),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .state_run    (state_run)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: combinational read, synchronous write, word index addr[5:2]
   assign mem_rdata = mem[mem_addr[5:2]];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [WIDTH-1:0] boot_data [4];

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      boot_data[0] = 32'h002081B3;
      boot_data[1] = 32'h403202B3;
      boot_data[2] = 32'h00308383;
      boot_data[3] = 32'h0000006F;
      for (int i = 0; i < 16; i++) mem[i] = '0;

      rst_n      = 1'b0;
      load_done  = 1'b0;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      load_req   = 1'b0;
      load_addr  = '0;
      load_wdata = '0;

      // Reset state
      #2;
      check("rst_state_run", 32'(state_run), 32'd0);
      check("rst_rvalid", 32'(fetch_rvalid), 32'd0);
      check("rst_rdata", fetch_rdata, 32'd0);
      check("rst_err", 32'(fetch_err), 32'd0);
      check("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
      check("rst_load_gnt", 32'(load_gnt), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // 1: BOOT loads with concurrent fetch request held off
      fetch_req  = 1'b1;
      fetch_addr = 32'd0;
      for (int i = 0; i < 4; i++) begin
         load_req   = 1'b1;
         load_addr  = 32'(i * 4);
         load_wdata = boot_data[i];
         #1;
         check("boot_load_gnt", 32'(load_gnt), 32'd1);
         check("boot_mem_we", 32'(mem_we), 32'd1);
         check("boot_mem_addr", mem_addr, 32'(i * 4));
         check("boot_mem_wdata", mem_wdata, boot_data[i]);
         check("boot_fetch_gnt", 32'(fetch_gnt), 32'd0);
         step();
         check("boot_no_rvalid", 32'(fetch_rvalid), 32'd0);
      end
      load_req  = 1'b0;
      fetch_req = 1'b0;
      #1;
      check("boot_idle_mem_addr", mem_addr, 32'd0);
      check("boot_idle_load_gnt", 32'(load_gnt), 32'd0);

      // 2: load_done -> RUN, single fetch
      step();
      load_done = 1'b1;
      #1;
      check("done_still_boot", 32'(state_run), 32'd0);
      step();
      load_done = 1'b0;
      check("run_state", 32'(state_run), 32'd1);
      fetch_req  = 1'b1;
      fetch_addr = 32'd4;
      #1;
      check("run_fetch_gnt", 32'(fetch_gnt), 32'd1);
      check("run_fetch_mem_addr", mem_addr, 32'd4);
      check("run_fetch_mem_we", 32'(mem_we), 32'd0);
      step();
      fetch_req = 1'b0;
      check("run_rvalid", 32'(fetch_rvalid), 32'd1);
      check("run_rdata", fetch_rdata, 32'h403202B3);
      check("run_err", 32'(fetch_err), 32'd0);
      step();
      check("run_rvalid_drop", 32'(fetch_rvalid), 32'd0);
      check("run_rdata_hold", fetch_rdata, 32'h403202B3);
      load_done = 1'b1;
      step();
      load_done = 1'b0;
      check("run_done_ignored", 32'(state_run), 32'd1);

      // RUN, loader alone granted immediately
      load_req   = 1'b1;
      load_addr  = 32'd20;
      load_wdata = 32'h12345678;
      #1;
      check("run_load_alone_gnt", 32'(load_gnt), 32'd1);
      check("run_load_alone_we", 32'(mem_we), 32'd1);
      step();

      // 3: starvation bound, fetch and load both held high
      fetch_req  = 1'b1;
      fetch_addr = 32'd0;
      load_addr  = 32'd16;
      load_wdata = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("starve_load_denied", 32'(load_gnt), 32'd0);
         check("starve_fetch_gnt", 32'(fetch_gnt), 32'd1);
         step();
      end
      #1;
      check("forced_load_gnt", 32'(load_gnt), 32'd1);
      check("forced_fetch_gnt", 32'(fetch_gnt), 32'd0);
      check("forced_mem_we", 32'(mem_we), 32'd1);
      check("forced_mem_addr", mem_addr, 32'd16);
      step();
      check("forced_no_rvalid", 32'(fetch_rvalid), 32'd0);
      check("forced_write_mem", mem[4], 32'hDEADBEEF);
      #1;
      check("wait_cleared_load_denied", 32'(load_gnt), 32'd0);
      check("wait_cleared_fetch_gnt", 32'(fetch_gnt), 32'd1);
      load_req = 1'b0;
      step();

      // 4: back-to-back fetches 0,4,8,12
      for (int i = 0; i < 4; i++) begin
         fetch_addr = 32'(i * 4);
         #1;
         check("b2b_fetch_gnt", 32'(fetch_gnt), 32'd1);
         step();
         check("b2b_rvalid", 32'(fetch_rvalid), 32'd1);
         check("b2b_rdata", fetch_rdata, boot_data[i]);
      end
      fetch_req = 1'b0;
      step();
      check("b2b_rvalid_end", 32'(fetch_rvalid), 32'd0);

      // 5: reset mid-RUN with a fetch in flight
      fetch_req  = 1'b1;
      fetch_addr = 32'd8;
      step();
      check("pre_rst_rvalid", 32'(fetch_rvalid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_rvalid", 32'(fetch_rvalid), 32'd0);
      check("midrst_state_run", 32'(state_run), 32'd0);
      check("midrst_fetch_gnt", 32'(fetch_gnt), 32'd0);
      fetch_req = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      load_done = 1'b1;
      step();
      load_done = 1'b0;
      check("rerun_state", 32'(state_run), 32'd1);

      // 6: misaligned fetch and load
      fetch_req  = 1'b1;
      fetch_addr = 32'd6;
      #1;
      check("mis_fetch_gnt", 32'(fetch_gnt), 32'd1);
`ifdef IMEM_MISALIGN_CHECK_EN
      check("mis_fetch_mem_addr", mem_addr, 32'd0);
`else
      check("mis_fetch_mem_addr", mem_addr, 32'd6);
`endif
      step();
      fetch_req = 1'b0;
      check("mis_rvalid", 32'(fetch_rvalid), 32'd1);
`ifdef IMEM_MISALIGN_CHECK_EN
      check("mis_err", 32'(fetch_err), 32'd1);
      check("mis_rdata", fetch_rdata, 32'd0);
`else
      check("mis_err", 32'(fetch_err), 32'd0);
      check("mis_rdata", fetch_rdata, 32'h403202B3);
`endif
      load_req   = 1'b1;
      load_addr  = 32'd2;
      load_wdata = 32'hCAFEF00D;
      #1;
      check("mis_load_gnt", 32'(load_gnt), 32'd1);
`ifdef IMEM_MISALIGN_CHECK_EN
      check("mis_load_we", 32'(mem_we), 32'd0);
      check("mis_load_mem_addr", mem_addr, 32'd0);
`else
      check("mis_load_we", 32'(mem_we), 32'd1);
      check("mis_load_mem_addr", mem_addr, 32'd2);
`endif
      step();
      load_req = 1'b0;
      check("mis_err_clear_rvalid", 32'(fetch_rvalid), 32'd0);
      step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
